// File: rtl/seq_mult18_pkg.sv
// Shared definitions for the seq_mult18 multiplier and its initiators.
// Holds the controller state encoding and the operand conventions.
package seq_mult18_pkg;

    // Default operand width and bit-counter width (2**CNT_W must exceed WIDTH).
    localparam int WIDTH_DEF = 18;
    localparam int CNT_W_DEF = 5;

    // Fixed-point 1.0 in the logistic datapath (two integer bits, 16 fraction bits).
    localparam logic [WIDTH_DEF-1:0] FIX_ONE = 18'h1_0000;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } mult_state_e;

endpackage

// File: rtl/seq_mult18_if.sv
// calc_start/done multiply handshake between a function unit
// (master, the initiator) and the shared multiplier (slave, the responder).
interface seq_mult18_if #(
    parameter int WIDTH = seq_mult18_pkg::WIDTH_DEF
);
    logic               calc_start;
    logic [WIDTH-1:0]   dataa;
    logic [WIDTH-1:0]   datab;
    logic [2*WIDTH-1:0] result;
    logic               done;
    logic               busy;

    modport master (
        output calc_start,
        output dataa,
        output datab,
        input  result,
        input  done,
        input  busy
    );

    modport slave (
        input  calc_start,
        input  dataa,
        input  datab,
        output result,
        output done,
        output busy
    );
endinterface

// File: rtl/seq_mult18.sv
// Sequential radix-2 shift-add unsigned multiplier, one product bit per clock.
// Level handshake: calc_start high requests, done high holds the result until release.
module seq_mult18
    import seq_mult18_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    seq_mult18_if.slave bus
);

    localparam int RW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mult_state_e      state_q, state_d;
    logic [RW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [RW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    result_q, result_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [RW-1:0]    sum;

    // State and datapath registers; reset clears everything at once, mid-operation too.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Controller and shift-add step; the final add feeds result directly.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = done_q;
        busy_d   = busy_q;
        sum      = acc_q + (mplier_q[0] ? mcand_q : '0);

        unique case (state_q)
            ST_IDLE: begin
                done_d = 1'b0;
                busy_d = 1'b0;
                if (bus.calc_start) begin
                    mcand_d  = {{WIDTH{1'b0}}, bus.dataa};
                    mplier_d = bus.datab;
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.calc_start) begin
                    // Abort: drop the partial product, keep the old result.
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    acc_d    = sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        result_d = sum;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!bus.calc_start) begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_seq_mult18.sv
// Self-checking bench for seq_mult18: cycle model plus directed vectors.
// The model computes products arithmetically and counts latency down.
module tb_seq_mult18;
    import seq_mult18_pkg::*;

    localparam int W = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    seq_mult18_if #(.WIDTH(W)) bus();

    seq_mult18 #(.WIDTH(W), .CNT_W(5)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: 0 idle, 1 multiplying, 2 holding.
    int           m_st   = 0;
    int           m_left = 0;
    logic [35:0]  m_prod = '0;
    logic [35:0]  m_res  = '0;
    logic         m_done = 1'b0;
    logic         m_busy = 1'b0;

    task automatic chk(input string name, input logic [35:0] act,
                       input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0; m_res = '0; m_done = 1'b0; m_busy = 1'b0;
        end else begin
            case (m_st)
                0: begin
                    if (bus.calc_start) begin
                        m_prod = 36'(longint'(bus.dataa) * longint'(bus.datab));
                        m_left = W;
                        m_busy = 1'b1;
                        m_st   = 1;
                    end
                end
                1: begin
                    if (!bus.calc_start) begin
                        m_busy = 1'b0;
                        m_st   = 0;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_res  = m_prod;
                            m_done = 1'b1;
                            m_busy = 1'b0;
                            m_st   = 2;
                        end
                    end
                end
                default: begin
                    if (!bus.calc_start) begin
                        m_done = 1'b0;
                        m_st   = 0;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #1;
        chk("cyc_done", 36'(bus.done), 36'(m_done));
        chk("cyc_busy", 36'(bus.busy), 36'(m_busy));
        chk("cyc_result", bus.result, m_res);
        if (bus.done && bus.busy) chk("done_busy_excl", 36'd1, 36'd0);
    end

    // Start a multiply at a negedge; capture happens on the next posedge.
    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.dataa      = a;
        bus.datab      = b;
        bus.calc_start = 1'b1;
        @(posedge clk);
    endtask

    // Count edges after capture until done, bounded.
    task automatic wait_done(input string name, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.done && n < 40);
        chk({name, "_latency"}, 36'(n), 36'(W));
    endtask

    task automatic release_start();
        @(negedge clk);
        bus.calc_start = 1'b0;
        @(posedge clk);
        #1;
        chk("release_done", 36'(bus.done), 36'd0);
    endtask

    int n;

    initial begin
        bus.calc_start = 1'b0;
        bus.dataa      = '0;
        bus.datab      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", bus.result, 36'd0);
        chk("reset_done", 36'(bus.done), 36'd0);
        chk("reset_busy", 36'(bus.busy), 36'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic 3*5 with busy over the whole run.
        start(18'd3, 18'd5);
        #1;
        chk("basic_busy", 36'(bus.busy), 36'd1);
        wait_done("basic", n);
        chk("basic_result", bus.result, 36'h0_0000_000F);
        chk("model_basic", m_res, 36'h0_0000_000F);
        release_start();

        // Reset mid-run, then a clean multiply.
        start(18'h3FFFF, 18'h3FFFF);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.calc_start = 1'b0;
        #1;
        chk("rst_mid_result", bus.result, 36'd0);
        chk("rst_mid_done", 36'(bus.done), 36'd0);
        chk("rst_mid_busy", 36'(bus.busy), 36'd0);
        @(negedge clk);
        rst = 1'b0;
        start(18'd3, 18'd5);
        wait_done("after_rst", n);
        chk("after_rst_result", bus.result, 36'h0_0000_000F);
        release_start();

        // Maximum operands.
        start(18'h3FFFF, 18'h3FFFF);
        wait_done("max", n);
        chk("max_result", bus.result, 36'hF_FFF8_0001);
        chk("model_max", m_res, 36'hF_FFF8_0001);
        release_start();

        // Logistic-style operands; operand change after capture is ignored.
        start(18'h10240, 18'h0FDC0);
        @(negedge clk);
        bus.dataa = '0;
        wait_done("logi", n);
        chk("logi_result", bus.result, 36'h0_FFFA_F000);
        chk("model_logi", m_res, 36'h0_FFFA_F000);
        release_start();

        // Zero operand still takes full latency.
        start(18'd0, FIX_ONE);
        wait_done("zero", n);
        chk("zero_result", bus.result, 36'd0);
        release_start();

        // Abort at cycle 10 keeps the prior result.
        start(18'd3, 18'd5);
        wait_done("pre_abort", n);
        release_start();
        start(18'h2AAAA, 18'h15555);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.calc_start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("abort_done", 36'(bus.done), 36'd0);
        chk("abort_busy", 36'(bus.busy), 36'd0);
        chk("abort_result", bus.result, 36'h0_0000_000F);

        // Hold calc_start high for 40 cycles after done: no restart.
        start(18'd11, 18'd13);
        wait_done("hold", n);
        repeat (40) @(posedge clk);
        #1;
        chk("hold_done", 36'(bus.done), 36'd1);
        chk("hold_result", bus.result, 36'd143);
        release_start();
        chk("hold_result_kept", bus.result, 36'd143);
        start(18'd7, 18'd9);
        wait_done("restart", n);
        chk("restart_result", bus.result, 36'd63);
        release_start();

        repeat (3) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
